pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction fetch stage for the MIPS single-cycle core, directly upstream of the main control decoder. It owns the program counter and issues word reads to instruction memory through a req/ready handshake. It holds each fetched instruction stable, with its opcode field, for the decoder and datapath. When the instruction is acknowledged, it computes the next PC from the branch/jump controls fed back by the decoder and datapath.

## Interface
- ADDR_W, 32, PC and instruction-memory address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  word-aligned fetch address (equals pc_out)
- imem_ready  in  1  memory accepts request; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  held instruction register
- opcode  out  6  instr[31:26], to control decoder
- pc_out  out  ADDR_W  address of the held instruction
- pc_plus4  out  ADDR_W  pc_out + 4 (jal link value)
- instr_valid  out  1  instr/opcode valid for execution
- instr_ack  in  1  datapath has executed the held instruction this cycle
- branch  in  1  decoder branch control
- zero  in  1  ALU zero flag
- jmp  in  1  decoder jump control (j/jal)
- jr  in  1  register-indirect jump
- jr_target  in  ADDR_W  register value for jr
- addr_err  out  1  one-cycle pulse: jr_target misaligned
- retire_cnt  out  32  count of acknowledged instructions

## Operation
- FSM states:
  - RST: entered on reset. Go to FETCH next cycle.
  - FETCH: imem_req=1 and imem_addr=pc_out. On imem_ready, load instr<=imem_rdata and go to HOLD.
  - HOLD: instr_valid=1. On instr_ack, load PC<=next_pc, increment retire_cnt, and go to FETCH.
- next_pc priority is jr > jmp > (branch & zero) > pc_plus4:
  - jr: {jr_target[ADDR_W-1:2], 2'b00}. If jr_target[1:0]≠0, pulse addr_err in the cycle after ack.
  - jmp: {pc_plus4[31:28], instr[25:0], 2'b00}
  - branch taken: pc_plus4 + (sign_extend(instr[15:0]) << 2)
- All PC arithmetic is modulo 2^ADDR_W. Wrap at 32'hFFFF_FFFC + 4 gives 0 with no error.
- branch, zero, jmp, jr and jr_target are sampled only in the cycle where HOLD and instr_ack are both high. They are ignored otherwise.
- instr_ack outside HOLD is ignored. retire_cnt is unchanged.
- imem_rdata outside FETCH is ignored.
- retire_cnt wraps from 32'hFFFF_FFFF to 0.
- Reset values:
  - PC=RESET_PC and pc_plus4=RESET_PC+4.
  - instr=0 (NOP), so opcode=0.
  - instr_valid=0, imem_req=0, addr_err=0, retire_cnt=0.
- Reset mid-operation: assertion immediately (asynchronously) drops imem_req and instr_valid and restores all reset values. A pending memory response is discarded.

## Timing
- First imem_req is asserted in the first cycle after the first rising edge with rst high (the RST cycle).
- imem_addr and imem_req are held stable in FETCH until imem_ready. Wait states are unbounded.
- Fetch latency: imem_ready in cycle N gives instr_valid=1 from cycle N+1.
- Minimum per-instruction period is 2 cycles: ready with zero wait, then ack in the first HOLD cycle.
- The next imem_req is asserted in the cycle after ack, with the new PC.
- opcode and instr are registered. They change only on the FETCH→HOLD transition or reset, so the decoder sees stable input throughout HOLD.
- pc_plus4 is combinational from the PC register.

## Test plan
- Reset and sequential fetch:
  - Stimulus: RESET_PC=0, zero-wait memory, ack every HOLD cycle.
  - Response: imem_addr sequence 0,4,8; retire_cnt=3 after three acks.
- Wait states:
  - Stimulus: imem_ready held low 3 cycles at addr 0x10.
  - Response: addr stays 0x10 with req=1; instr_valid rises exactly 1 cycle after ready.
- Branch:
  - Stimulus: at PC=0x20, instr imm=16'hFFFE, branch=1, zero=1.
  - Response: next imem_addr=0x1C.
  - Stimulus: same instruction with zero=0.
  - Response: next imem_addr=0x24.
- Jump, jr and priority:
  - Stimulus: at PC=0x4000_0000, jmp with instr[25:0]=26'h100.
  - Response: next addr=0x4000_0400.
  - Stimulus: jr=1 and jmp=1, jr_target=0x0000_0103.
  - Response: next addr=0x100; addr_err pulses 1 cycle.
- Wrap-around:
  - Stimulus: PC=0xFFFF_FFFC, sequential ack.
  - Response: next addr=0x0000_0000 with no error; retire_cnt wraps from 0xFFFF_FFFF to 0.
- Async reset mid-fetch:
  - Stimulus: drop rst while in FETCH waiting on memory.
  - Response: imem_req=0 and instr_valid=0 before the next clock edge; PC=RESET_PC; the late imem_ready is ignored.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake,
// holds the instruction for the decoder and picks the next PC once it is acknowledged.
module pc_fetch #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              branch,
  input  logic              zero,
  input  logic              jmp,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  output logic              addr_err,
  output logic [31:0]       retire_cnt
);

  typedef enum logic [1:0] {
    ST_RST,
    ST_FETCH,
    ST_HOLD
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic              r_req;
  logic              r_valid;
  logic              r_addrErr;
  logic [31:0]       r_retire;

  logic [ADDR_W-1:0] w_pcPlus4;
  logic [ADDR_W-1:0] w_branchOff;
  logic [ADDR_W-1:0] w_nextPc;

  assign w_pcPlus4   = r_pc + ADDR_W'(4);
  assign w_branchOff = {{(ADDR_W-18){r_instr[15]}}, r_instr[15:0], 2'b00};

  // Redirect priority: jr, then jump, then taken branch, then fall-through.
  always_comb begin
    w_nextPc = w_pcPlus4;
    if (jr) begin
      w_nextPc = {jr_target[ADDR_W-1:2], 2'b00};
    end else if (jmp) begin
      w_nextPc = {w_pcPlus4[ADDR_W-1:28], r_instr[25:0], 2'b00};
    end else if (branch && zero) begin
      w_nextPc = w_pcPlus4 + w_branchOff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RST;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_addrErr <= 1'b0;
      r_retire  <= '0;
    end else begin
      r_addrErr <= 1'b0;
      case (r_state)
        ST_RST: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Redirect controls are only meaningful in the acknowledge cycle.
          if (instr_ack) begin
            r_pc      <= w_nextPc;
            r_retire  <= r_retire + 32'd1;
            r_addrErr <= jr && (jr_target[1:0] != 2'b00);
            r_valid   <= 1'b0;
            r_req     <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_RST;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign pc_plus4    = w_pcPlus4;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign instr_valid = r_valid;
  assign addr_err    = r_addrErr;
  assign retire_cnt  = r_retire;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: the driver plays instruction memory and the datapath,
// a reference model predicts fetch addresses, and a monitor checks every new request.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jmp = 1'b0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        addr_err;
  logic [31:0] retire_cnt;

  pc_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode),
    .pc_out(pc_out), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid), .instr_ack(instr_ack),
    .branch(branch), .zero(zero), .jmp(jmp), .jr(jr), .jr_target(jr_target),
    .addr_err(addr_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] retire;
    logic        err;
  } fetch_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } hold_t;

  fetch_t expFetchQ[$];
  hold_t  expHoldQ[$];

  int nTests = 0;
  int nFails = 0;

  logic [31:0] mPc = 32'h0;
  logic [31:0] mRetire = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC rule written as plain arithmetic on the held instruction.
  function automatic logic [31:0] modelNext(input logic [31:0] pc, input logic [31:0] word,
                                            input logic br, input logic z, input logic j,
                                            input logic r, input logic [31:0] tgt);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(word[15:0]));
    if (r) return tgt & 32'hFFFF_FFFC;
    if (j) return (seq & 32'hF000_0000) | ({6'b0, word[25:0]} << 2);
    if (br && z) return seq + 32'(off * 4);
    return seq;
  endfunction

  // Monitor: every new request must match the next predicted fetch.
  logic        prevReq = 1'b0;
  logic        prevValid = 1'b0;
  logic [31:0] heldAddr = '0;

  always @(negedge clk) begin
    fetch_t f;
    hold_t  h;
    if (imem_req && !prevReq) begin
      if (expFetchQ.size() == 0) begin
        nTests++;
        nFails++;
        $display("[TB] FAIL unexpectedFetch: got addr %h expected no request", imem_addr);
      end else begin
        f = expFetchQ.pop_front();
        check("fetchAddr", imem_addr, f.addr);
        check("retireCnt", retire_cnt, f.retire);
        check("addrErr", {31'b0, addr_err}, {31'b0, f.err});
      end
      heldAddr = imem_addr;
    end else begin
      if (addr_err) begin
        nTests++;
        nFails++;
        $display("[TB] FAIL strayAddrErr: got 1 expected 0");
      end
      if (imem_req && prevReq) check("addrStable", imem_addr, heldAddr);
    end
    if (instr_valid && !prevValid) begin
      if (expHoldQ.size() == 0) begin
        nTests++;
        nFails++;
        $display("[TB] FAIL unexpectedValid: got valid with instr %h expected none", instr);
      end else begin
        h = expHoldQ.pop_front();
        check("instr", instr, h.word);
        check("opcode", {26'b0, opcode}, {26'b0, h.word[31:26]});
        check("pcOut", pc_out, h.pc);
        check("pcPlus4", pc_plus4, h.pc + 32'd4);
      end
    end
    prevReq   = imem_req;
    prevValid = instr_valid;
  end

  task automatic randomCtl();
    branch    = 1'($urandom_range(0, 1));
    zero      = 1'($urandom_range(0, 1));
    jmp       = 1'($urandom_range(0, 1));
    jr        = 1'($urandom_range(0, 1));
    jr_target = $urandom;
  endtask

  task automatic waitReq();
    for (int i = 0; i < 40; i++) begin
      if (imem_req) return;
      @(negedge clk);
    end
    $display("[TB] FAIL reqTimeout: got no imem_req expected one within 40 cycles");
    $fatal(1, "[TB] fetch request never arrived");
  endtask

  // Plays memory and datapath for one instruction.
  task automatic applyStimulus(input logic [31:0] word, input int waits, input int ackDelay,
                               input logic br, input logic z, input logic j, input logic r,
                               input logic [31:0] tgt);
    logic [31:0] nxt;
    waitReq();
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      instr_ack  = 1'($urandom_range(0, 1));
      randomCtl();
      @(negedge clk);
      check("validLowInWait", {31'b0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    instr_ack  = 1'($urandom_range(0, 1));
    expHoldQ.push_back('{pc: mPc, word: word});
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("validAfterReady", {31'b0, instr_valid}, 32'd1);
    for (int d = 0; d < ackDelay; d++) begin
      instr_ack = 1'b0;
      randomCtl();
      @(negedge clk);
      check("instrStable", instr, word);
    end
    instr_ack = 1'b1;
    branch    = br;
    zero      = z;
    jmp       = j;
    jr        = r;
    jr_target = tgt;
    nxt       = modelNext(mPc, word, br, z, j, r, tgt);
    mRetire   = mRetire + 32'd1;
    expFetchQ.push_back('{addr: nxt, retire: mRetire, err: r && (tgt[1:0] != 2'b00)});
    mPc = nxt;
    @(negedge clk);
    instr_ack = 1'b0;
    randomCtl();
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_pc"}, pc_out, 32'h0);
    check({tag, "_pcPlus4"}, pc_plus4, 32'h4);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_opcode"}, {26'b0, opcode}, 32'h0);
    check({tag, "_retire"}, retire_cnt, 32'h0);
    check({tag, "_addrErr"}, {31'b0, addr_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] w;
    expFetchQ.push_back('{addr: 32'h0, retire: 32'h0, err: 1'b0});
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst = 1'b1;

    // Sequential fetch 0,4,8,C with zero-wait memory and immediate acks.
    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    // Wait states at 0x10, then branch forward to 0x20.
    applyStimulus({6'h04, 10'h0, 16'h0003}, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus({6'h04, 10'h0, 16'hFFFE}, 0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus({6'h04, 10'h0, 16'hFFFE}, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // jr to 0x4000_0000, jump there, then jr beating jmp with a misaligned target.
    applyStimulus($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0000);
    applyStimulus({6'h02, 26'h100}, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus({6'h02, 26'h3FF_FFFF}, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    // Wrap-around at the top of the address space.
    applyStimulus($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus($urandom, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      applyStimulus(w, $urandom_range(0, 3), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom);
    end

    // Asynchronous reset while a fetch is waiting on memory.
    waitReq();
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1 checkOutput("asyncReset");
    @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ready = 1'b0;
    check("lateReadyIgnored", instr, 32'h0);
    mPc     = 32'h0;
    mRetire = 32'h0;
    expFetchQ.push_back('{addr: 32'h0, retire: 32'h0, err: 1'b0});
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus($urandom, $urandom_range(0, 2), $urandom_range(0, 1),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0);
    end
    waitReq();
    repeat (3) @(negedge clk);
    check("fetchQueueDrained", 32'(expFetchQ.size()), 32'd0);
    check("holdQueueDrained", 32'(expHoldQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
